// File: rtl/pwqe_slot_pkg.sv
// Shared slot-state encoding and default sizing for the PWQE station-buffer slot manager.
package pwqe_slot_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_READY    = 2'd1,
        SLOT_INFLIGHT = 2'd2
    } slot_state_t;

    localparam int PWQE_SLOT_NUM_DEF       = 4;
    localparam int PWQE_BUF_ADDR_WIDTH_DEF = $clog2(PWQE_SLOT_NUM_DEF);

endpackage

// File: rtl/pwqe_rr_arb.sv
// N-way masked round-robin priority encoder: first set req bit after ptr, wrapping to 0.
module pwqe_rr_arb #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] ptr,
    output logic          gnt_val,
    output logic [AW-1:0] gnt_idx
);

    int idx;

    // Walk from farthest to nearest so the slot right after ptr wins last.
    always_comb begin
        gnt_val = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_val = 1'b1;
                gnt_idx = AW'(idx);
            end
        end
    end

endmodule

// File: rtl/pwqe_slot_mgr.sv
// Owns the PWQE station-buffer slots of the bandwidth-sensitive group: allocation,
// round-robin selection, writeback/release tracking and status export.
module pwqe_slot_mgr
    import pwqe_slot_pkg::*;
#(
    parameter int PWQE_SLOT_NUM       = PWQE_SLOT_NUM_DEF,
    parameter int PWQE_BUF_ADDR_WIDTH = $clog2(PWQE_SLOT_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_alloc_req,
    output logic                           o_alloc_ack,
    output logic                           o_alloc_ok,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_alloc_addr,
    input  logic                           i_sel_req,
    output logic                           o_sel_ack,
    output logic                           o_sel_ok,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_sel_addr,
    input  logic                           i_wb,
    input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic                           i_free,
    input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_free_addr,
    output logic [PWQE_SLOT_NUM-1:0]       o_slot_status,
    output logic [PWQE_SLOT_NUM-1:0]       o_slot_ready,
    output logic [PWQE_BUF_ADDR_WIDTH:0]   o_free_cnt,
    output logic                           o_err
);

    localparam int N  = PWQE_SLOT_NUM;
    localparam int AW = PWQE_BUF_ADDR_WIDTH;

    slot_state_t   slot_q [N];
    slot_state_t   slot_d [N];
    logic [N-1:0]  ready_cur;
    logic          alloc_found;
    logic [AW-1:0] alloc_idx;
    logic          sel_found;
    logic [AW-1:0] sel_idx;
    logic [AW-1:0] rr_ptr;
    logic          wb_bad;
    logic          free_bad;
    logic [N-1:0]  status_d;
    logic [N-1:0]  ready_d;
    logic [AW:0]   free_cnt_d;

    pwqe_rr_arb #(.N(N), .AW(AW)) u_rr_arb (
        .req     (ready_cur),
        .ptr     (rr_ptr),
        .gnt_val (sel_found),
        .gnt_idx (sel_idx)
    );

    // Eligibility and error checks look only at slot_q, the state at the request edge.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        ready_cur   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            ready_cur[i] = (slot_q[i] == SLOT_READY);
            if (slot_q[i] == SLOT_FREE) begin
                alloc_found = 1'b1;
                alloc_idx   = AW'(i);
            end
        end

        wb_bad   = i_wb   && (slot_q[i_wb_addr]   != SLOT_INFLIGHT);
        free_bad = i_free && (slot_q[i_free_addr] == SLOT_FREE);

        for (int i = 0; i < N; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (i_alloc_req && alloc_found) slot_d[alloc_idx] = SLOT_READY;
        if (i_sel_req && sel_found)     slot_d[sel_idx]   = SLOT_INFLIGHT;
        if (i_wb && !wb_bad)            slot_d[i_wb_addr] = SLOT_READY;
        // Release is applied last so it overrides a same-cycle writeback or select.
        if (i_free && !free_bad)        slot_d[i_free_addr] = SLOT_FREE;

        status_d   = '0;
        ready_d    = '0;
        free_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            status_d[i] = (slot_d[i] != SLOT_FREE);
            ready_d[i]  = (slot_d[i] == SLOT_READY);
            if (slot_d[i] == SLOT_FREE) free_cnt_d = free_cnt_d + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            rr_ptr        <= AW'(N - 1);
            o_alloc_ack   <= 1'b0;
            o_alloc_ok    <= 1'b0;
            o_alloc_addr  <= '0;
            o_sel_ack     <= 1'b0;
            o_sel_ok      <= 1'b0;
            o_sel_addr    <= '0;
            o_slot_status <= '0;
            o_slot_ready  <= '0;
            o_free_cnt    <= (AW+1)'(N);
            o_err         <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
            end
            o_alloc_ack <= i_alloc_req;
            o_alloc_ok  <= i_alloc_req && alloc_found;
            if (i_alloc_req && alloc_found) o_alloc_addr <= alloc_idx;
            o_sel_ack <= i_sel_req;
            o_sel_ok  <= i_sel_req && sel_found;
            if (i_sel_req && sel_found) begin
                o_sel_addr <= sel_idx;
                rr_ptr     <= sel_idx;
            end
            o_slot_status <= status_d;
            o_slot_ready  <= ready_d;
            o_free_cnt    <= free_cnt_d;
            if (wb_bad || free_bad) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwqe_slot_mgr.sv
// Directed and randomized bench for pwqe_slot_mgr against a slot-level reference model.
module tb_pwqe_slot_mgr;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int ST_FREE = 0, ST_READY = 1, ST_INFL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_alloc_req = 1'b0;
    logic          o_alloc_ack, o_alloc_ok;
    logic [AW-1:0] o_alloc_addr;
    logic          i_sel_req = 1'b0;
    logic          o_sel_ack, o_sel_ok;
    logic [AW-1:0] o_sel_addr;
    logic          i_wb = 1'b0;
    logic [AW-1:0] i_wb_addr = '0;
    logic          i_free = 1'b0;
    logic [AW-1:0] i_free_addr = '0;
    logic [N-1:0]  o_slot_status, o_slot_ready;
    logic [AW:0]   o_free_cnt;
    logic          o_err;

    pwqe_slot_mgr #(.PWQE_SLOT_NUM(N), .PWQE_BUF_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_alloc_req(i_alloc_req), .o_alloc_ack(o_alloc_ack), .o_alloc_ok(o_alloc_ok),
        .o_alloc_addr(o_alloc_addr),
        .i_sel_req(i_sel_req), .o_sel_ack(o_sel_ack), .o_sel_ok(o_sel_ok), .o_sel_addr(o_sel_addr),
        .i_wb(i_wb), .i_wb_addr(i_wb_addr), .i_free(i_free), .i_free_addr(i_free_addr),
        .o_slot_status(o_slot_status), .o_slot_ready(o_slot_ready),
        .o_free_cnt(o_free_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    // Reference model: per-slot lifecycle plus last-chosen slot for round robin.
    int m_st [N];
    int m_last;
    int e_aack, e_aok, e_aaddr, e_sack, e_sok, e_saddr, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_st[i] = ST_FREE;
        m_last  = N - 1;
        e_aack  = 0; e_aok = 0; e_aaddr = 0;
        e_sack  = 0; e_sok = 0; e_saddr = 0;
        e_err   = 0;
    endtask

    task automatic model_step(input bit a, input bit s, input bit w, input int wa,
                              input bit f, input int fa);
        int pre [N];
        int best, bd, d;
        for (int i = 0; i < N; i++) pre[i] = m_st[i];
        e_aack = a; e_aok = 0;
        if (a) begin
            for (int i = N - 1; i >= 0; i--)
                if (pre[i] == ST_FREE) begin e_aok = 1; e_aaddr = i; end
            if (e_aok) m_st[e_aaddr] = ST_READY;
        end
        e_sack = s; e_sok = 0;
        if (s) begin
            best = -1; bd = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_last - 1 + 2 * N) % N;
                if (pre[i] == ST_READY && d < bd) begin bd = d; best = i; end
            end
            if (best >= 0) begin
                e_sok = 1; e_saddr = best; m_last = best; m_st[best] = ST_INFL;
            end
        end
        if (w) begin
            if (pre[wa] == ST_INFL) m_st[wa] = ST_READY;
            else e_err = 1;
        end
        if (f) begin
            if (pre[fa] != ST_FREE) m_st[fa] = ST_FREE;
            else e_err = 1;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] es, er;
        int cnt;
        es = '0; er = '0; cnt = 0;
        for (int i = 0; i < N; i++) begin
            es[i] = (m_st[i] != ST_FREE);
            er[i] = (m_st[i] == ST_READY);
            if (m_st[i] == ST_FREE) cnt++;
        end
        chk("alloc_ack", 32'(o_alloc_ack), 32'(e_aack));
        chk("alloc_ok", 32'(o_alloc_ok), 32'(e_aok));
        chk("alloc_addr", 32'(o_alloc_addr), 32'(e_aaddr));
        chk("sel_ack", 32'(o_sel_ack), 32'(e_sack));
        chk("sel_ok", 32'(o_sel_ok), 32'(e_sok));
        chk("sel_addr", 32'(o_sel_addr), 32'(e_saddr));
        chk("slot_status", 32'(o_slot_status), 32'(es));
        chk("slot_ready", 32'(o_slot_ready), 32'(er));
        chk("free_cnt", 32'(o_free_cnt), 32'(cnt));
        chk("err", 32'(o_err), 32'(e_err));
    endtask

    task automatic cyc(input bit r, input bit a, input bit s, input bit w, input int wa,
                       input bit f, input int fa);
        rst         = r;
        i_alloc_req = a;
        i_sel_req   = s;
        i_wb        = w;
        i_wb_addr   = AW'(wa);
        i_free      = f;
        i_free_addr = AW'(fa);
        if (r) model_reset();
        else   model_step(a, s, w, wa, f, fa);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int wa, fa;
        bit a, s, w, f;

        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_free_cnt", 32'(o_free_cnt), 32'd4);

        // Fill all slots, then one allocation too many.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("alloc_seq_addr", 32'(o_alloc_addr), 32'(k));
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("alloc_full_ok", 32'(o_alloc_ok), 32'd0);
        chk("alloc_full_cnt", 32'(o_free_cnt), 32'd0);

        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            chk("sel_seq_addr", 32'(o_sel_addr), 32'(k));
        end
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("sel_none_ok", 32'(o_sel_ok), 32'd0);
        chk("sel_none_ready", 32'(o_slot_ready), 32'd0);

        // Round-robin wrap with slots 0 and 2 ready and pointer on 2.
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rr_prep_addr", 32'(o_sel_addr), 32'd2);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rr_wrap_first", 32'(o_sel_addr), 32'd0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rr_wrap_second", 32'(o_sel_addr), 32'd2);

        cyc(0, 0, 0, 1, 1, 1, 1);
        chk("wb_free_cnt", 32'(o_free_cnt), 32'd1);
        chk("wb_free_err", 32'(o_err), 32'd0);

        // Writeback concurrent with select is invisible to that select.
        cyc(0, 0, 1, 1, 3, 0, 0);
        chk("wb_sel_ok", 32'(o_sel_ok), 32'd0);
        chk("wb_sel_ready", 32'(o_slot_ready), 32'b1000);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("wb_sel_next", 32'(o_sel_addr), 32'd3);

        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("err_set", 32'(o_err), 32'd1);
        idle();
        idle();
        chk("err_sticky", 32'(o_err), 32'd1);

        // Reset with requests pending.
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        idle();
        chk("mid_rst_ack", 32'(o_alloc_ack), 32'd0);
        chk("mid_rst_cnt", 32'(o_free_cnt), 32'd4);

        for (int n = 0; n < 800; n++) begin
            if (n % 97 == 96) begin
                cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
            end else begin
                a  = ($urandom_range(0, 99) < 40);
                s  = ($urandom_range(0, 99) < 45);
                wa = $urandom_range(0, N - 1);
                fa = $urandom_range(0, N - 1);
                w  = ($urandom_range(0, 1) == 1) &&
                     (m_st[wa] == ST_INFL || $urandom_range(0, 29) == 0);
                f  = ($urandom_range(0, 99) < 15) &&
                     (m_st[fa] != ST_FREE || $urandom_range(0, 29) == 0);
                cyc(0, a, s, w, wa, f, fa);
            end
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
